// File: rtl/cpu_trace_dumper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trace_dumper_pkg
// Description : Shared constants for the end-of-run trace dumper: FSM state
//               encodings, beat kind codes and a register-select width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_trace_dumper_pkg;

    localparam int ST_W = 4;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_RUN      = 4'd1;
    localparam logic [3:0] ST_CAP      = 4'd2;
    localparam logic [3:0] ST_BEAT_PC  = 4'd3;
    localparam logic [3:0] ST_BEAT_IN  = 4'd4;
    localparam logic [3:0] ST_REG_SEL  = 4'd5;
    localparam logic [3:0] ST_REG_OUT  = 4'd6;
    localparam logic [3:0] ST_BEAT_CNT = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    localparam logic [1:0] KIND_PC    = 2'd0;
    localparam logic [1:0] KIND_INSTR = 2'd1;
    localparam logic [1:0] KIND_REG   = 2'd2;
    localparam logic [1:0] KIND_CNT   = 2'd3;

    // A single-register file still needs a 1-bit select bus.
    function automatic int rsel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_trace_dumper_trace_beat_slot.sv
`default_nettype none
// ============================================================================
// Module      : trace_beat_slot
// Description : One-entry valid/ready holding register. A load captures a
//               beat and raises valid; the beat holds until accepted
//               (valid & ready) or flushed.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               flush          - drop any held beat
//               load/load_data - capture a new beat (overrides a beat being
//                                accepted in the same cycle)
//               ready          - sink accepts the held beat
//               valid/data     - held beat
// Revision    : 1.0 - initial release
// ============================================================================
module trace_beat_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/cpu_trace_dumper.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trace_dumper
// Description : End-of-run monitor for the single-cycle RISC-V core. Counts
//               retired cycles until a halt PC or the cycle limit, then
//               streams PC, instruction, every register (read through the
//               core debug port) and the cycle count as valid/ready beats.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               enable                - arm the monitor (level)
//               halt_pc, pc_valid, pc, instr - retirement interface
//               reg_sel / reg_data    - register-file debug port
//               out_valid/out_ready/out_kind/out_idx/out_data - beat stream
//               cycle_cnt, done, timeout - run status
//               trace_ovf             - trace beat dropped (trace build only)
// Options     : CPU_TRACE_DUMPER_TRACE_EN - emit a PC beat for every
//               non-halting retire during the run.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_trace_dumper
    import cpu_trace_dumper_pkg::*;
#(
    parameter int  XLEN       = 32,
    parameter int  NREG       = 32,
    parameter int  MAX_CYCLES = 1000,
    parameter int  RD_LAT     = 0,
    parameter int  CNT_W      = 32,
    localparam int RSEL_W     = rsel_width(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [XLEN-1:0]   halt_pc,
    input  logic              pc_valid,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   instr,
    output logic [RSEL_W-1:0] reg_sel,
    input  logic [XLEN-1:0]   reg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_kind,
    output logic [RSEL_W-1:0] out_idx,
    output logic [XLEN-1:0]   out_data,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              done,
`ifdef CPU_TRACE_DUMPER_TRACE_EN
    output logic              trace_ovf,
`endif
    output logic              timeout
);

    localparam int                c_beat_w   = 2 + RSEL_W + XLEN;
    localparam logic [RSEL_W-1:0] c_last_idx = RSEL_W'(NREG - 1);
    localparam logic [CNT_W-1:0]  c_max_cnt  = CNT_W'(MAX_CYCLES);
    // A limit above the saturation value can never be reached.
    localparam bit                c_lim_ok   = (CNT_W >= 31) || (MAX_CYCLES < (1 << CNT_W));

    logic [ST_W-1:0]   r_state;
    logic [RSEL_W-1:0] r_idx;
    logic              r_wait;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_cap_pc;
    logic [XLEN-1:0]   r_cap_instr;
    logic              r_done;
    logic              r_timeout;
    logic              r_ovf;

    logic              w_hs;
    logic              w_halt;
    logic              w_limit;
    logic              w_rd_ready;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [XLEN-1:0]   w_cnt_beat;
    logic              w_load;
    logic              w_flush;
    logic [1:0]        w_beat_kind;
    logic [RSEL_W-1:0] w_beat_idx;
    logic [XLEN-1:0]   w_beat_data;
    logic [c_beat_w-1:0] w_slot_data;

    assign w_hs       = out_valid & out_ready;
    assign w_halt     = pc_valid && (pc == halt_pc);
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_limit    = c_lim_ok && (w_cnt_next == c_max_cnt);
    // With a registered debug port the select must settle for one extra cycle.
    assign w_rd_ready = (RD_LAT == 0) || r_wait;

    generate
        if (CNT_W >= XLEN) begin : g_cnt_trunc
            assign w_cnt_beat = r_cnt[XLEN-1:0];
        end else begin : g_cnt_ext
            assign w_cnt_beat = {{(XLEN-CNT_W){1'b0}}, r_cnt};
        end
    endgenerate

    // Beat generation: each state loads the slot with the next beat, usually
    // on the edge that accepts the previous one.
    always_comb begin
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_beat_kind = KIND_PC;
        w_beat_idx  = '0;
        w_beat_data = '0;
        case (r_state)
            ST_RUN: begin
                if (!enable || w_halt || (pc_valid && w_limit)) begin
                    w_flush = 1'b1;
`ifdef CPU_TRACE_DUMPER_TRACE_EN
                end else if (pc_valid && (!out_valid || out_ready)) begin
                    w_load      = 1'b1;
                    w_beat_data = pc;
`endif
                end
            end
            ST_CAP: begin
                w_load      = 1'b1;
                w_beat_data = r_cap_pc;
            end
            ST_BEAT_PC: begin
                if (w_hs) begin
                    w_load      = 1'b1;
                    w_beat_kind = KIND_INSTR;
                    w_beat_data = r_cap_instr;
                end
            end
            ST_REG_SEL: begin
                if (w_rd_ready) begin
                    w_load      = 1'b1;
                    w_beat_kind = KIND_REG;
                    w_beat_idx  = r_idx;
                    w_beat_data = (r_idx == '0) ? '0 : reg_data;
                end
            end
            ST_REG_OUT: begin
                if (w_hs && (r_idx == c_last_idx)) begin
                    w_load      = 1'b1;
                    w_beat_kind = KIND_CNT;
                    w_beat_data = w_cnt_beat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_wait      <= 1'b0;
            r_cnt       <= '0;
            r_cap_pc    <= '0;
            r_cap_instr <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ovf <= 1'b0;
                    if (enable) begin
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                        r_done    <= 1'b0;
                        r_idx     <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_halt) begin
                        // Halt takes precedence over the limit in the same cycle.
                        r_cap_pc    <= pc;
                        r_cap_instr <= instr;
                        r_state     <= ST_CAP;
                    end else if (pc_valid) begin
                        r_cnt <= w_cnt_next;
                        if (w_limit) begin
                            r_timeout   <= 1'b1;
                            r_cap_pc    <= pc;
                            r_cap_instr <= instr;
                            r_state     <= ST_CAP;
                        end else if (out_valid && !out_ready) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                ST_CAP: begin
                    r_state <= ST_BEAT_PC;
                end
                ST_BEAT_PC: begin
                    if (w_hs) begin
                        r_state <= ST_BEAT_IN;
                    end
                end
                ST_BEAT_IN: begin
                    if (w_hs) begin
                        r_idx   <= '0;
                        r_wait  <= 1'b0;
                        r_state <= ST_REG_SEL;
                    end
                end
                ST_REG_SEL: begin
                    if (w_rd_ready) begin
                        r_wait  <= 1'b0;
                        r_state <= ST_REG_OUT;
                    end else begin
                        r_wait  <= 1'b1;
                    end
                end
                ST_REG_OUT: begin
                    if (w_hs) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= ST_BEAT_CNT;
                        end else begin
                            r_idx   <= r_idx + {{(RSEL_W-1){1'b0}}, 1'b1};
                            r_state <= ST_REG_SEL;
                        end
                    end
                end
                ST_BEAT_CNT: begin
                    if (w_hs) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    trace_beat_slot #(
        .W (c_beat_w)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_flush),
        .load      (w_load),
        .load_data ({w_beat_kind, w_beat_idx, w_beat_data}),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (w_slot_data)
    );

    assign {out_kind, out_idx, out_data} = w_slot_data;
    assign reg_sel   = r_idx;
    assign cycle_cnt = r_cnt;
    assign done      = r_done;
    assign timeout   = r_timeout;
`ifdef CPU_TRACE_DUMPER_TRACE_EN
    assign trace_ovf = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_trace_dumper
// Description : Scoreboard bench for cpu_trace_dumper. Two instances share
//               stimulus: lane a with a combinational debug port (RD_LAT=0),
//               lane b with a registered one (RD_LAT=1). Expected beats are
//               queued by a run model; per-lane monitors pop and compare.
// Options     : CPU_TRACE_DUMPER_TRACE_EN - also checks trace beats/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_trace_dumper;
    import cpu_trace_dumper_pkg::*;

    localparam int NREG = 32;
    localparam int MAXC = 40;

    typedef struct packed {
        logic [1:0]  k;
        logic [4:0]  i;
        logic [31:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pc_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] halt_pc = '0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] regs [NREG];
    int          rmode = 0;
    int          total = 0;
    int          bad = 0;
    beat_t       q_a[$];
    beat_t       q_b[$];
    logic        held [2];
    beat_t       held_b [2];

    logic [4:0]  reg_sel_a, reg_sel_b, out_idx_a, out_idx_b;
    logic [31:0] reg_data_a, reg_data_b, out_data_a, out_data_b;
    logic [1:0]  out_kind_a, out_kind_b;
    logic [31:0] cycle_cnt_a, cycle_cnt_b;
    logic        out_valid_a, out_valid_b, done_a, done_b, timeout_a, timeout_b;
`ifdef CPU_TRACE_DUMPER_TRACE_EN
    logic        trace_ovf_a, trace_ovf_b;
`endif

    always #5 clk = ~clk;

    assign reg_data_a = regs[reg_sel_a];
    always @(posedge clk) reg_data_b <= regs[reg_sel_b];

    cpu_trace_dumper #(.XLEN(32), .NREG(NREG), .MAX_CYCLES(MAXC), .RD_LAT(0), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .halt_pc(halt_pc), .pc_valid(pc_valid),
        .pc(pc), .instr(instr), .reg_sel(reg_sel_a), .reg_data(reg_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_kind(out_kind_a),
        .out_idx(out_idx_a), .out_data(out_data_a), .cycle_cnt(cycle_cnt_a), .done(done_a),
`ifdef CPU_TRACE_DUMPER_TRACE_EN
        .trace_ovf(trace_ovf_a),
`endif
        .timeout(timeout_a));

    cpu_trace_dumper #(.XLEN(32), .NREG(NREG), .MAX_CYCLES(MAXC), .RD_LAT(1), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .halt_pc(halt_pc), .pc_valid(pc_valid),
        .pc(pc), .instr(instr), .reg_sel(reg_sel_b), .reg_data(reg_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_kind(out_kind_b),
        .out_idx(out_idx_b), .out_data(out_data_b), .cycle_cnt(cycle_cnt_b), .done(done_b),
`ifdef CPU_TRACE_DUMPER_TRACE_EN
        .trace_ovf(trace_ovf_b),
`endif
        .timeout(timeout_b));

    // Sink: always ready, ready 1-of-3 cycles on average, or stalled.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) == 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic monitor(input int ln, input logic v, input beat_t b);
        beat_t e;
        if (rst) begin
            held[ln] = 1'b0;
            return;
        end
        if (held[ln]) begin
            total++;
            if (!v || b !== held_b[ln]) begin
                bad++;
                $display("FAIL hold lane%0d: got v=%0b k=%0d i=%0d d=%h, need v=1 k=%0d i=%0d d=%h",
                         ln, v, b.k, b.i, b.d, held_b[ln].k, held_b[ln].i, held_b[ln].d);
            end
        end
        if (v && out_ready) begin
            total++;
            if ((ln == 0 ? q_a.size() : q_b.size()) == 0) begin
                bad++;
                $display("FAIL extra_beat lane%0d: got k=%0d i=%0d d=%h, need no beat", ln, b.k, b.i, b.d);
            end else begin
                if (ln == 0) e = q_a.pop_front();
                else         e = q_b.pop_front();
                if (b !== e) begin
                    bad++;
                    $display("FAIL beat lane%0d: got k=%0d i=%0d d=%h, need k=%0d i=%0d d=%h",
                             ln, b.k, b.i, b.d, e.k, e.i, e.d);
                end
            end
            held[ln] = 1'b0;
        end else begin
            held[ln] = v;
        end
        held_b[ln] = b;
    endtask

    always @(negedge clk) monitor(0, out_valid_a, {out_kind_a, out_idx_a, out_data_a});
    always @(negedge clk) monitor(1, out_valid_b, {out_kind_b, out_idx_b, out_data_b});

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h need %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input logic [1:0] k, input int i, input logic [31:0] d);
        beat_t b;
        b.k = k;
        b.i = 5'(i);
        b.d = d;
        return b;
    endfunction

    task automatic push_both(input beat_t b);
        q_a.push_back(b);
        q_b.push_back(b);
    endtask

    // Full end-of-run dump: PC, INSTR, r0 forced to zero, r1..r31, CYCLES.
    task automatic push_dump(input logic [31:0] lp, input logic [31:0] li, input int cnt);
        push_both(mk(KIND_PC, 0, lp));
        push_both(mk(KIND_INSTR, 0, li));
        for (int i = 0; i < NREG; i++) push_both(mk(KIND_REG, i, (i == 0) ? 32'd0 : regs[i]));
        push_both(mk(KIND_CNT, 0, 32'(cnt)));
    endtask

    task automatic wait_done(input bit exp_to, input int exp_cnt, input int dmode);
        int n = 0;
        rmode = dmode;
        while (!(done_a && done_b) && n < 3000) begin
            tick();
            n++;
        end
        chk("done_a", done_a, 1);
        chk("done_b", done_b, 1);
        chk("timeout_a", timeout_a, exp_to);
        chk("timeout_b", timeout_b, exp_to);
        chk("cycle_cnt_a", cycle_cnt_a, exp_cnt);
        chk("cycle_cnt_b", cycle_cnt_b, exp_cnt);
        chk("beats_left_a", q_a.size(), 0);
        chk("beats_left_b", q_b.size(), 0);
        rmode = 0;
        enable = 1'b0;
        tick();
        tick();
        chk("done_clr_a", done_a, 0);
        chk("done_clr_b", done_b, 0);
`ifdef CPU_TRACE_DUMPER_TRACE_EN
        chk("ovf_clr_a", trace_ovf_a, 0);
`endif
    endtask

    // Retire pcs 0,4,8,... with random gaps; the run ends on halt_pc or at
    // the MAXC-th counted retire, whichever the model reaches first.
    task automatic do_run(input int nnh, input bit use_halt, input int dmode);
        int cnt = 0;
        bit to = 1'b0;
        logic [31:0] p, ins;
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        halt_pc = use_halt ? 32'(4 * nnh) : 32'hFFFF_FFF0;
        rmode = 0;
        enable = 1'b1;
        tick();
        for (int k = 0; k < 1000; k++) begin
            pc_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            p = 32'(4 * k);
            ins = $urandom;
            pc_valid = 1'b1;
            pc = p;
            instr = ins;
            if (p == halt_pc) begin
                push_dump(p, ins, cnt);
                tick();
                break;
            end
            cnt++;
            if (cnt == MAXC) begin
                to = 1'b1;
                push_dump(p, ins, cnt);
                tick();
                break;
            end
`ifdef CPU_TRACE_DUMPER_TRACE_EN
            push_both(mk(KIND_PC, 0, p));
`endif
            tick();
        end
        pc_valid = 1'b0;
        wait_done(to, cnt, dmode);
    endtask

    task automatic retire_nh(input logic [31:0] p);
        pc_valid = 1'b1;
        pc = p;
        instr = $urandom;
`ifdef CPU_TRACE_DUMPER_TRACE_EN
        push_both(mk(KIND_PC, 0, p));
`endif
        tick();
    endtask

    initial begin
        logic [31:0] ins;
        int n;
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        repeat (3) tick();
        chk("rst_valid_a", out_valid_a, 0);
        chk("rst_valid_b", out_valid_b, 0);
        chk("rst_done", done_a, 0);
        chk("rst_timeout", timeout_a, 0);
        chk("rst_cnt", cycle_cnt_a, 0);
        chk("rst_reg_sel", reg_sel_a, 0);
        rst = 1'b0;
        tick();

        // enable dropped mid-run: count held, then cleared on re-arm
        halt_pc = 32'hFFFF_FFF0;
        enable = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) retire_nh(32'(4 * k));
        pc_valid = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        chk("hold_cnt_a", cycle_cnt_a, 5);
        chk("hold_cnt_b", cycle_cnt_b, 5);
        chk("idle_valid", out_valid_a, 0);
        enable = 1'b1;
        tick();
        chk("rearm_cnt", cycle_cnt_a, 0);

        do_run(28, 1'b1, 0);         // halt at 0x70 after 28 counted retires
        do_run(0, 1'b0, 0);          // timeout at MAXC
        do_run(MAXC - 1, 1'b1, 0);   // halt on the limit retire: halt wins
        do_run(10, 1'b1, 1);         // backpressure
        do_run(0, 1'b0, 1);          // timeout under backpressure
        do_run(0, 1'b1, 1);          // halt on the very first retire

        // reset in the middle of the register walk
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        halt_pc = 32'h8;
        enable = 1'b1;
        tick();
        retire_nh(32'h0);
        retire_nh(32'h4);
        ins = $urandom;
        pc_valid = 1'b1;
        pc = 32'h8;
        instr = ins;
        push_dump(32'h8, ins, 2);
        tick();
        pc_valid = 1'b0;
        n = 0;
        while (!(out_valid_a && out_kind_a == KIND_REG && out_idx_a == 5'd7) && n < 500) begin
            tick();
            n++;
        end
        chk("reach_r7", out_valid_a && out_kind_a == KIND_REG && out_idx_a == 5'd7, 1);
        rst = 1'b1;
        enable = 1'b0;
        tick();
        chk("mid_rst_valid_a", out_valid_a, 0);
        chk("mid_rst_valid_b", out_valid_b, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_cnt", cycle_cnt_a, 0);
        q_a.delete();
        q_b.delete();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", out_valid_a | out_valid_b, 0);
        do_run(12, 1'b1, 1);

`ifdef CPU_TRACE_DUMPER_TRACE_EN
        // two retires with a stalled sink: first held, second dropped
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        halt_pc = 32'h200;
        rmode = 2;
        enable = 1'b1;
        tick();
        pc_valid = 1'b1;
        pc = 32'h100;
        instr = $urandom;
        tick();
        pc = 32'h104;
        tick();
        pc_valid = 1'b0;
        tick();
        chk("ovf_a", trace_ovf_a, 1);
        chk("ovf_b", trace_ovf_b, 1);
        chk("trace_held_valid", out_valid_a, 1);
        chk("trace_held_data", out_data_a, 32'h100);
        push_both(mk(KIND_PC, 0, 32'h100));
        rmode = 0;
        tick();
        tick();
        ins = $urandom;
        pc_valid = 1'b1;
        pc = 32'h200;
        instr = ins;
        push_dump(32'h200, ins, 2);
        tick();
        pc_valid = 1'b0;
        wait_done(1'b0, 2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, need finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
